// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART-to-register-bus bridge.
// Command/response bytes are ASCII so a terminal session can drive the link by hand.
package uart_pkg;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RspOk    = 8'h4B;
  localparam logic [7:0] RspErr   = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_RESP
  } bridge_state_e;

endpackage

// File: rtl/uart_bus_bridge.sv
// Decodes W/R command frames from the UART byte stream into single register-bus
// transactions and streams the response frame back to the transmitter.
//
// state       | meaning
// ST_IDLE     | waiting for a command byte
// ST_ADDR     | collecting address bytes, MSB first
// ST_DATA     | collecting write-data bytes, MSB first
// ST_BUS_REQ  | bus_req_o high until granted
// ST_BUS_WAIT | read granted, waiting for rvalid
// ST_RESP     | streaming the response shift register to tx
module uart_bus_bridge
  import uart_pkg::*;
#(
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_data_i,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  input  logic                 bus_gnt_i,
  input  logic                 bus_rvalid_i,
  input  logic [DataWidth-1:0] bus_rdata_i,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int unsigned AddrBytes = AddrWidth / 8;
  localparam int unsigned DataBytes = DataWidth / 8;
  localparam int unsigned MaxBytes  = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
  localparam int unsigned CntW      = $clog2(MaxBytes + 1);
  localparam int unsigned TmoW      = $clog2(TimeoutCycles + 1);

  bridge_state_e        state_q, state_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rsp_q, rsp_d;
  logic                 single_q, single_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 overrun_q, overrun_d;
  logic                 tmo_hit;
  logic                 rsp_last;

  // Timeout fires on the clock that would bring the idle count up to TimeoutCycles.
  assign tmo_hit  = ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                    (tmo_q == TmoW'(TimeoutCycles - 1));
  assign rsp_last = single_q || (cnt_q == CntW'(DataBytes - 1));

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_d     = rsp_q;
    single_d  = single_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    overrun_d = overrun_q;

    if (rx_dv_i && ((state_q == ST_BUS_REQ) || (state_q == ST_BUS_WAIT) ||
                    (state_q == ST_RESP))) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_dv_i) begin
          cnt_d = '0;
          if ((rx_data_i == CmdWrite) || (rx_data_i == CmdRead)) begin
            we_d    = (rx_data_i == CmdWrite);
            state_d = ST_ADDR;
          end else begin
            rsp_d    = DataWidth'(RspErr) << (DataWidth - 8);
            single_d = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (tmo_hit) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (rx_dv_i) begin
          addr_d = (addr_q << 8) | AddrWidth'(rx_data_i);
          if (cnt_q == CntW'(AddrBytes - 1)) begin
            cnt_d   = '0;
            state_d = we_q ? ST_DATA : ST_BUS_REQ;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      ST_DATA: begin
        if (tmo_hit) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (rx_dv_i) begin
          wdata_d = (wdata_q << 8) | DataWidth'(rx_data_i);
          if (cnt_q == CntW'(DataBytes - 1)) begin
            cnt_d   = '0;
            state_d = ST_BUS_REQ;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      ST_BUS_REQ: begin
        if (bus_gnt_i) begin
          cnt_d = '0;
          if (we_q) begin
            rsp_d    = DataWidth'(RspOk) << (DataWidth - 8);
            single_d = 1'b1;
            state_d  = ST_RESP;
          end else if (bus_rvalid_i) begin
            rsp_d    = bus_rdata_i;
            single_d = 1'b0;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_BUS_WAIT;
          end
        end
      end
      ST_BUS_WAIT: begin
        if (bus_rvalid_i) begin
          rsp_d    = bus_rdata_i;
          single_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_ready_i) begin
          if (rsp_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            rsp_d = rsp_q << 8;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_q     <= '0;
      single_q  <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_q     <= rsp_d;
      single_q  <= single_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx_valid_o  = (state_q == ST_RESP);
  assign tx_data_o   = rsp_q[DataWidth-1 -: 8];
  assign bus_req_o   = (state_q == ST_BUS_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench: directed frames plus randomized frames against a queue-based
// model of expected bus transactions and response bytes.
module tb_uart_bus_bridge;
  import uart_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 100;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_dv_i = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          tx_valid_o;
  logic [7:0]    tx_data_o;
  logic          tx_ready_i;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_gnt_i;
  logic          bus_rvalid_i;
  logic [DW-1:0] bus_rdata_i;
  logic          busy_o;
  logic          overrun_o;

  always #5 clk_i = ~clk_i;

  uart_bus_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_dv_i(rx_dv_i), .rx_data_i(rx_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  int errors = 0;
  int checks = 0;

  txn_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  logic [7:0] frm[$];
  logic       exp_ovr = 1'b0;

  int         dir_gnt = 0;
  int         dir_rv = -1;
  logic       hold_ready = 1'b0;

  int            req_age = 0;
  bit            pend_rd = 1'b0;
  int            rv_cnt = 0;
  int            cur_gnt = 1;
  int            cur_rv = 0;
  logic [AW-1:0] rd_addr = '0;
  int            last_len = 0;
  logic          last_we = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;

  logic          prev_req = 1'b0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  // Slave register contents: a fixed function of the address.
  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a ^ 16'hB76E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Bus slave and tx sink, driven on the falling edge.
  initial begin
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; tx_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      tx_ready_i   = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (!rst_ni) begin
        req_age = 0;
        pend_rd = 1'b0;
      end else if (pend_rd) begin
        if (rv_cnt == 0) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rd_fn(rd_addr);
          pend_rd      = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (bus_req_o) begin
        if (req_age == 0) begin
          cur_gnt = (dir_gnt > 0) ? dir_gnt : int'($urandom_range(1, 4));
          cur_rv  = (dir_rv >= 0) ? dir_rv : int'($urandom_range(0, 4));
        end
        req_age++;
        if (req_age == cur_gnt) begin
          bus_gnt_i  = 1'b1;
          last_len   = req_age;
          req_age    = 0;
          last_we    = bus_we_o;
          last_addr  = bus_addr_o;
          last_wdata = bus_wdata_o;
          if (!bus_we_o) begin
            if (cur_rv == 0) begin
              bus_rvalid_i = 1'b1;
              bus_rdata_i  = rd_fn(bus_addr_o);
            end else begin
              pend_rd = 1'b1;
              rv_cnt  = cur_rv - 1;
              rd_addr = bus_addr_o;
            end
          end
        end
      end
    end
  end

  // Compare process: bus transactions, tx bytes, request stability and overrun.
  initial begin
    txn_t t;
    logic [7:0] b;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_ni) begin
        prev_req = 1'b0;
      end else begin
        if (bus_req_o && prev_req)
          chk("req_stable", {bus_we_o, bus_addr_o, bus_wdata_o},
              {prev_we, prev_addr, prev_wdata});
        prev_req   = bus_req_o;
        prev_we    = bus_we_o;
        prev_addr  = bus_addr_o;
        prev_wdata = bus_wdata_o;
        if (bus_req_o && bus_gnt_i) begin
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got access addr %0h we %0b, expected none",
                     bus_addr_o, bus_we_o);
          end else begin
            t = exp_bus.pop_front();
            chk("bus_we", bus_we_o, t.we);
            chk("bus_addr", bus_addr_o, t.addr);
            if (t.we) chk("bus_wdata", bus_wdata_o, t.wdata);
          end
        end
        if (tx_valid_o && tx_ready_i) begin
          tx_log.push_back(tx_data_o);
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got byte %0h, expected none", tx_data_o);
          end else begin
            b = exp_tx.pop_front();
            chk("tx_byte", tx_data_o, b);
          end
        end
        chk("overrun", overrun_o, exp_ovr);
      end
    end
  end

  // Caller is positioned at a falling edge; returns at the next one.
  task automatic drive(input logic [7:0] b);
    rx_dv_i   = 1'b1;
    rx_data_i = b;
    @(negedge clk_i);
    rx_dv_i   = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < frm.size(); i++) begin
      drive(frm[i]);
      if (i != frm.size() - 1) repeat ($urandom_range(0, maxgap)) @(negedge clk_i);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (busy_o) begin
      errors++;
      $display("FAIL %s: busy_o still 1 after %0d cycles, expected 0", nm, n);
    end
    chk({nm, "_bus_drained"}, exp_bus.size(), 0);
    chk({nm, "_tx_drained"}, exp_tx.size(), 0);
  endtask

  task automatic prep_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = 1'b1; t.addr = a; t.wdata = d;
    exp_bus.push_back(t);
    exp_tx.push_back(RspOk);
    frm.delete();
    frm.push_back(CmdWrite);
    for (int i = AW/8 - 1; i >= 0; i--) frm.push_back(a[i*8 +: 8]);
    for (int i = DW/8 - 1; i >= 0; i--) frm.push_back(d[i*8 +: 8]);
  endtask

  task automatic prep_read(input logic [AW-1:0] a);
    txn_t t;
    logic [DW-1:0] d;
    t.we = 1'b0; t.addr = a; t.wdata = '0;
    exp_bus.push_back(t);
    d = rd_fn(a);
    for (int i = DW/8 - 1; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    frm.delete();
    frm.push_back(CmdRead);
    for (int i = AW/8 - 1; i >= 0; i--) frm.push_back(a[i*8 +: 8]);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit stable;
    int k;

    repeat (3) @(negedge clk_i);
    chk("rst_outputs",
        {tx_valid_o, tx_data_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, busy_o, overrun_o},
        64'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed write, grant on the third request cycle.
    dir_gnt = 3; dir_rv = 0; tx_log.delete();
    prep_write(16'h0002, 16'hBEEF);
    send_frame(0);
    chk("wr_req_latency", bus_req_o, 1'b1);
    wait_idle("wr");
    chk("wr_req_len", last_len, 3);
    chk("wr_addr", last_addr, 16'h0002);
    chk("wr_wdata", last_wdata, 16'hBEEF);
    chk("wr_we", last_we, 1'b1);
    chk("wr_tx_count", tx_log.size(), 1);
    chk("wr_tx0", tx_log[0], 8'h4B);

    // Directed read, immediate grant, rvalid five cycles later.
    dir_gnt = 1; dir_rv = 5; tx_log.delete();
    prep_read(16'h1234);
    send_frame(2);
    wait_idle("rd");
    chk("rd_addr", last_addr, 16'h1234);
    chk("rd_we", last_we, 1'b0);
    chk("rd_tx_count", tx_log.size(), 2);
    chk("rd_tx0", tx_log[0], 8'hA5);
    chk("rd_tx1", tx_log[1], 8'h5A);

    // Bad command held by tx backpressure.
    hold_ready = 1'b1; tx_log.delete(); last_len = 0;
    @(negedge clk_i);
    exp_tx.push_back(RspErr);
    frm.delete(); frm.push_back(8'h41);
    send_frame(0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!(tx_valid_o && tx_data_o == 8'h45 && !bus_req_o)) stable = 1'b0;
      @(negedge clk_i);
    end
    chk("bad_hold_stable", stable, 1'b1);
    hold_ready = 1'b0;
    wait_idle("bad");
    chk("bad_tx_count", tx_log.size(), 1);
    chk("bad_tx0", tx_log[0], 8'h45);
    chk("bad_no_bus", last_len, 0);

    // Inter-byte timeout aborts the frame silently.
    dir_gnt = 0; dir_rv = -1; tx_log.delete();
    drive(CmdWrite);
    drive(8'h00);
    repeat (TMO + 10) @(negedge clk_i);
    chk("tmo_idle", busy_o, 1'b0);
    chk("tmo_no_tx", tx_log.size(), 0);
    prep_read(16'h0001);
    send_frame(3);
    wait_idle("tmo_rd");
    chk("tmo_rd_addr", last_addr, 16'h0001);

    // Overrun during BUS_WAIT of a read.
    dir_gnt = 1; dir_rv = 8; tx_log.delete();
    prep_read(16'h0005);
    send_frame(0);
    repeat (3) @(negedge clk_i);
    drive(8'h33);
    exp_ovr = 1'b1;
    wait_idle("ovr");
    chk("ovr_flag", overrun_o, 1'b1);
    chk("ovr_tx0", tx_log[0], 8'hB7);
    chk("ovr_tx1", tx_log[1], 8'h6B);

    // Randomized frames.
    dir_gnt = 0; dir_rv = -1;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        prep_write(16'($urandom), 16'($urandom));
      end else if (k < 8) begin
        prep_read(16'($urandom));
      end else begin
        do b = 8'($urandom_range(0, 255)); while (b == CmdWrite || b == CmdRead);
        exp_tx.push_back(RspErr);
        frm.delete(); frm.push_back(b);
      end
      send_frame(5);
      wait_idle("rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    // Reset while requesting the bus.
    dir_gnt = 1000;
    prep_write(16'h0010, 16'h1234);
    send_frame(0);
    @(negedge clk_i);
    chk("rst_mid_req_before", bus_req_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_req_async", bus_req_o, 1'b0);
    chk("rst_mid_outputs",
        {tx_valid_o, tx_data_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, busy_o, overrun_o},
        64'h0);
    exp_bus.delete(); exp_tx.delete(); exp_ovr = 1'b0;
    dir_gnt = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tx_log.delete();
    prep_write(16'h00AA, 16'h5555);
    send_frame(2);
    wait_idle("post_rst");
    chk("post_rst_addr", last_addr, 16'h00AA);
    chk("post_rst_wdata", last_wdata, 16'h5555);
    chk("post_rst_tx0", tx_log[0], 8'h4B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Bus initiator at the far end of the UART link: decodes command frames from the receive byte stream and issues single read/write transactions on the SoC register bus.
- Returns a response frame on the transmit byte stream.
- Sits between the uart_rx/uart_tx byte interfaces and a bus slave such as the UART controller's register port; this is the debug/host-load path.

Parameters:
- AddrWidth, 16, bus address width; multiple of 8.
- DataWidth, 16, bus data width; multiple of 8.
- TimeoutCycles, 1_000_000, max idle clocks between bytes of one frame before the frame is aborted.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rx_dv_i  in  1  one-cycle strobe, received byte valid; no backpressure
- rx_data_i  in  8  received byte
- tx_valid_o  out  1  response byte valid
- tx_data_o  out  8  response byte
- tx_ready_i  in  1  transmitter accepts byte when high together with tx_valid_o
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write, 0 = read
- bus_addr_o  out  AddrWidth  bus address
- bus_wdata_o  out  DataWidth  write data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  DataWidth  read data
- busy_o  out  1  high in any state other than IDLE
- overrun_o  out  1  sticky; a byte arrived while not accepting bytes

Behaviour:
- Only asynchronous reset is rst_ni = 0. Reset values: all outputs 0; state IDLE; counters 0; overrun_o 0.
- Reset mid-frame or mid-transaction abandons the frame immediately. bus_req_o drops asynchronously.
- Frame format, big-endian multi-byte fields:
  - Write: 0x57 'W', AddrWidth/8 address bytes, DataWidth/8 data bytes. Response: 0x4B 'K'.
  - Read: 0x52 'R', AddrWidth/8 address bytes. Response: DataWidth/8 bytes of read data, MSB first.
  - Any other command byte: response 0x45 'E'; no bus access.
- States:
  - IDLE: on rx_dv_i with 'W' or 'R', latch we and go to ADDR. With any other byte, load 'E' and go to RESP.
  - ADDR: shift each byte into the address register from the LSB side. After the last address byte: go to DATA if we = 1, else BUS_REQ.
  - DATA: shift bytes into the write-data register. After the last byte, go to BUS_REQ.
  - BUS_REQ: bus_req_o = 1 with stable addr/we/wdata until bus_gnt_i. In the gnt cycle, drop bus_req_o on the next edge.
    - Write: load 'K' and go to RESP.
    - Read: go to BUS_WAIT.
    - A grant at the first request cycle gives a single-cycle request.
  - BUS_WAIT: on bus_rvalid_i, capture bus_rdata_i into the response shift register and go to RESP. bus_rvalid_i coincident with bus_gnt_i is captured in the same cycle; BUS_WAIT is skipped.
  - RESP: tx_valid_o = 1, tx_data_o = current byte. Advance on tx_valid_o and tx_ready_i. After the last byte, go to IDLE. tx_data_o and tx_valid_o hold while tx_ready_i = 0.
- Byte counter width is clog2(max(AddrWidth, DataWidth)/8 + 1). It clears on every field transition.
- Inter-byte timeout:
  - Counter clears on each accepted byte and counts clocks only in ADDR and DATA.
  - When it reaches TimeoutCycles, return to IDLE with no response and no bus access.
  - A byte arriving in the same cycle as timeout is discarded.
- rx_dv_i while in BUS_REQ, BUS_WAIT or RESP: byte dropped, overrun_o set. overrun_o clears only on reset.
- rx_dv_i in the cycle RESP completes: byte dropped, counts as overrun. Bytes are accepted from the first IDLE cycle after RESP.
- Latency from the last frame byte's rx_dv_i to bus_req_o = 1: 1 cycle.

Decomposition:
- uart_pkg holds:
  - command/response byte constants: CmdWrite 0x57, CmdRead 0x52, RspOk 0x4B, RspErr 0x45;
  - the bridge state enum typedef.
- No sub-module is needed; the timeout counter stays inline.

Test Plan:
- Write, AddrWidth = DataWidth = 16:
  - stimulus: bytes 57 00 02 BE EF; gnt at the 3rd request cycle;
  - response: one write with addr 0x0002, wdata 0xBEEF, we = 1; req high exactly 3 cycles; tx 4B.
- Read with delayed rvalid:
  - stimulus: bytes 52 12 34; gnt immediately; rvalid with rdata 0xA55A after 5 cycles;
  - response: addr 0x1234, we = 0; tx A5 then 5A.
- Bad command and tx backpressure:
  - stimulus: byte 41; tx_ready_i low for 10 cycles;
  - response: tx 45 held stable 10 cycles; no bus_req_o; back to IDLE.
- Timeout, TimeoutCycles = 100:
  - stimulus: 57 00, then silence for 100 cycles, then 52 00 01;
  - response: first frame aborted with no tx; second frame reads addr 0x0001.
- Overrun:
  - stimulus: byte 33 injected during BUS_WAIT of a read;
  - response: overrun_o = 1 and stays high; read response unaffected.
- Reset mid-frame:
  - stimulus: rst_ni low during BUS_REQ;
  - response: bus_req_o = 0 immediately; all outputs 0; next frame 57 … processes normally.
